// File: rtl/gac_fwd_sel_unit.sv
// EX operand-mux forwarding select and load-use stall for the 5-stage pipeline.
// Optional WB-late forwarding (WB slot tracking, select 4) is enabled by GAC_FWD_WB_LATE_EN.
module gac_fwd_sel_unit #(
   parameter int unsigned REG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [REG_W-1:0] id_dst,
   input  logic             id_reg_write,
   input  logic             id_is_load,
   input  logic             id_imm_b,
   input  logic             id_link_a,
   input  logic             flush,
   output logic [2:0]       sel_a,
   output logic [2:0]       sel_b,
   output logic             ex_valid,
   output logic             stall_id
);

   localparam logic [2:0] SelReg    = 3'd0;
   localparam logic [2:0] SelExMem  = 3'd1;
   localparam logic [2:0] SelMemAlu = 3'd2;
   localparam logic [2:0] SelMemLd  = 3'd3;
   localparam logic [2:0] SelImm    = 3'd5;
   localparam logic [2:0] SelPc8    = 3'd6;
   localparam logic [2:0] SelZero   = 3'd7;
`ifdef GAC_FWD_WB_LATE_EN
   localparam logic [2:0] SelWbLate = 3'd4;
`endif

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dst;
      logic             reg_write;
      logic             is_load;
   } tag_t;

   tag_t       ex_q, ex_d, mem_q;
   logic [2:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
   logic       bubble;
`ifdef GAC_FWD_WB_LATE_EN
   tag_t       wb_q;
`endif

   function automatic logic is_prod(input tag_t t);
      return t.valid && t.reg_write && (t.dst != '0);
   endfunction

   // Nearest in-flight producer wins; SelReg means no EX/MEM match.
   function automatic logic [2:0] src_sel(input logic use_r, input logic [REG_W-1:0] r,
                                          input tag_t ex, input tag_t mem);
      if (!use_r || r == '0) return SelZero;
      if (is_prod(ex) && ex.dst == r) return SelExMem;
      if (is_prod(mem) && mem.dst == r) return mem.is_load ? SelMemLd : SelMemAlu;
      return SelReg;
   endfunction

   always_comb begin
      stall_id = id_valid && !flush && is_prod(ex_q) && ex_q.is_load &&
                 ((id_use_rs && ex_q.dst == id_rs) || (id_use_rt && ex_q.dst == id_rt));
      bubble = stall_id || flush || !id_valid;

      sel_a_d = src_sel(id_use_rs, id_rs, ex_q, mem_q);
      sel_b_d = src_sel(id_use_rt, id_rt, ex_q, mem_q);
`ifdef GAC_FWD_WB_LATE_EN
      if (sel_a_d == SelReg && is_prod(wb_q) && wb_q.dst == id_rs) sel_a_d = SelWbLate;
      if (sel_b_d == SelReg && is_prod(wb_q) && wb_q.dst == id_rt) sel_b_d = SelWbLate;
`endif
      if (id_link_a) sel_a_d = SelPc8;
      if (id_imm_b) sel_b_d = SelImm;

      ex_d = '0;
      if (!bubble) begin
         ex_d.valid     = 1'b1;
         ex_d.dst       = id_dst;
         ex_d.reg_write = id_reg_write;
         ex_d.is_load   = id_is_load;
      end else begin
         sel_a_d = SelZero;
         sel_b_d = SelZero;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q    <= '0;
         mem_q   <= '0;
         sel_a_q <= SelZero;
         sel_b_q <= SelZero;
`ifdef GAC_FWD_WB_LATE_EN
         wb_q    <= '0;
`endif
      end else begin
         ex_q    <= ex_d;
         mem_q   <= ex_q;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
`ifdef GAC_FWD_WB_LATE_EN
         wb_q    <= mem_q;
`endif
      end
   end

   assign sel_a    = sel_a_q;
   assign sel_b    = sel_b_q;
   assign ex_valid = ex_q.valid;

endmodule

// File: tb/tb_gac_fwd_sel_unit.sv
// Scoreboard bench for gac_fwd_sel_unit: driver queues expected EX outputs, monitor checks them.
module tb_gac_fwd_sel_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_is_load;
   logic       id_imm_b, id_link_a, flush;
   logic [4:0] id_rs, id_rt, id_dst;
   logic [2:0] sel_a, sel_b;
   logic       ex_valid, stall_id;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic       ev;
      logic [2:0] a;
      logic [2:0] b;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];

`ifdef GAC_FWD_WB_LATE_EN
   localparam logic [2:0] WbExp = 3'd4;
`else
   localparam logic [2:0] WbExp = 3'd0;
`endif

   always #5 clk = ~clk;

   gac_fwd_sel_unit #(.REG_W(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .id_dst      (id_dst),
      .id_reg_write(id_reg_write),
      .id_is_load  (id_is_load),
      .id_imm_b    (id_imm_b),
      .id_link_a   (id_link_a),
      .flush       (flush),
      .sel_a       (sel_a),
      .sel_b       (sel_b),
      .ex_valid    (ex_valid),
      .stall_id    (stall_id)
   );

   // Drive one ID cycle, check the combinational stall, queue the expected EX response.
   task automatic drive(input string nm, input logic r, input logic v,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic rw, input logic ld, input logic imm, input logic lnk,
                        input logic fl, input logic exp_st, input logic exp_ev,
                        input logic [2:0] ea, input logic [2:0] eb);
      exp_t e;
      @(negedge clk);
      rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_dst = dst; id_reg_write = rw; id_is_load = ld; id_imm_b = imm; id_link_a = lnk;
      flush = fl;
      #1;
      n_checks++;
      if (stall_id !== exp_st) begin
         n_errors++;
         $display("FAIL %s stall_id: got %b want %b", nm, stall_id, exp_st);
      end
      e.ev = exp_ev; e.a = ea; e.b = eb;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic alu(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] dst, input logic [2:0] ea, input logic [2:0] eb);
      drive(nm, 0, 1, rs, rt, 1, 1, dst, 1, 0, 0, 0, 0, 0, 1, ea, eb);
   endtask

   task automatic idle(input string nm);
      drive(nm, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 3'd7, 3'd7);
   endtask

   // Monitor: EX outputs appear one edge after the ID cycle that queued them.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (ex_valid !== e.ev || sel_a !== e.a || sel_b !== e.b) begin
               n_errors++;
               $display("FAIL %s ex: got ev=%b a=%0d b=%0d want ev=%b a=%0d b=%0d",
                        nm, ex_valid, sel_a, sel_b, e.ev, e.a, e.b);
            end
         end
      end
   end

   initial begin
      int wait_cnt;
      rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
      id_dst = 0; id_reg_write = 0; id_is_load = 0; id_imm_b = 0; id_link_a = 0; flush = 0;

      // Reset held two cycles, then release idle.
      drive("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd7, 3'd7);
      drive("rst1", 1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 3'd7, 3'd7);
      idle("post_rst");

      // Back-to-back ALU forwarding and MEM/WB distances.
      alu("add3",    5'd1, 5'd2,  5'd3,  3'd0, 3'd0);
      alu("sub_ex",  5'd3, 5'd7,  5'd8,  3'd1, 3'd0);
      alu("or_gap",  5'd9, 5'd10, 5'd11, 3'd0, 3'd0);
      alu("use_mem", 5'd8, 5'd3,  5'd16, 3'd2, WbExp);
      idle("d0"); idle("d1"); idle("d2");

      // Load-use: one bubble, then load data from MEM/WB.
      drive("lw5", 0, 1, 1, 0, 1, 0, 5, 1, 1, 1, 0, 0, 0, 1, 3'd0, 3'd5);
      drive("lu_stall", 0, 1, 5, 6, 1, 1, 12, 1, 0, 0, 0, 0, 1, 0, 3'd7, 3'd7);
      drive("lu_retry", 0, 1, 5, 6, 1, 1, 12, 1, 0, 0, 0, 0, 0, 1, 3'd3, 3'd0);
      idle("d3"); idle("d4"); idle("d5");

      // Nearest producer wins; $0 is never forwarded.
      alu("add4",    5'd1, 5'd2, 5'd4,  3'd0, 3'd0);
      alu("or4",     5'd1, 5'd2, 5'd4,  3'd0, 3'd0);
      alu("near4",   5'd4, 5'd4, 5'd13, 3'd1, 3'd1);
      alu("wr0",     5'd1, 5'd2, 5'd0,  3'd0, 3'd0);
      alu("rd0",     5'd0, 5'd0, 5'd17, 3'd7, 3'd7);
      drive("unused", 0, 1, 17, 17, 0, 0, 18, 1, 0, 0, 0, 0, 0, 1, 3'd7, 3'd7);
      idle("d6"); idle("d7"); idle("d8");

      // WB-late distance, immediate and link overrides.
      alu("p6",   5'd1, 5'd2, 5'd6,  3'd0, 3'd0);
      alu("u14",  5'd1, 5'd2, 5'd14, 3'd0, 3'd0);
      alu("u15",  5'd1, 5'd2, 5'd15, 3'd0, 3'd0);
      alu("wb6",  5'd1, 5'd6, 5'd19, 3'd0, WbExp);
      drive("imm", 0, 1, 1, 6, 1, 1, 20, 1, 0, 1, 0, 0, 0, 1, 3'd0, 3'd5);
      drive("link", 0, 1, 20, 2, 1, 1, 31, 1, 0, 0, 1, 0, 0, 1, 3'd6, 3'd0);
      idle("d9"); idle("d10"); idle("d11");

      // Flush overrides a load-use stall.
      drive("lw2", 0, 1, 1, 0, 1, 0, 2, 1, 1, 1, 0, 0, 0, 1, 3'd0, 3'd5);
      drive("flush", 0, 1, 2, 3, 1, 1, 21, 1, 0, 0, 0, 1, 0, 0, 3'd7, 3'd7);
      drive("after_fl", 0, 1, 2, 3, 1, 1, 21, 1, 0, 0, 0, 0, 0, 1, 3'd3, 3'd0);
      idle("d12"); idle("d13"); idle("d14");

      // Mid-operation reset drops in-flight tags.
      alu("p7", 5'd1, 5'd2, 5'd7, 3'd0, 3'd0);
      drive("rst_mid", 1, 1, 7, 7, 1, 1, 22, 1, 0, 0, 0, 0, 0, 0, 3'd7, 3'd7);
      alu("no_fwd7", 5'd7, 5'd7, 5'd23, 3'd0, 3'd0);
      idle("d15");

      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gac_fwd_sel_unit.md
# gac_fwd_sel_unit

Forwarding-select control for the EX-stage operand muxes of the 5-stage MIPS pipeline. Tracks destination-register tags of in-flight instructions across EX, MEM and WB, compares them against the source registers of the instruction in ID, and registers two 3-bit select codes that drive the `sel` inputs of the two 32-bit 8:1 operand muxes in EX. Also detects load-use hazards and raises a stall toward the fetch/decode stages.

## Interface
Parameters:
- `REG_W`, 5, register-number width.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt` in REG_W: source register numbers.
- `id_use_rs`, `id_use_rt` in 1: instruction actually reads rs / rt.
- `id_dst` in REG_W: destination register (already resolved rd/rt/31).
- `id_reg_write` in 1: instruction writes `id_dst`.
- `id_is_load` in 1: instruction is a load.
- `id_imm_b` in 1: operand B is the immediate.
- `id_link_a` in 1: operand A is PC+8 (jal/jalr/bgezal).
- `flush` in 1: discard the ID instruction (branch redirect).
- `sel_a`, `sel_b` out 3: registered EX operand-mux selects.
- `ex_valid` out 1: EX holds a real instruction.
- `stall_id` out 1: combinational; hold PC and IF/ID this cycle.

## Operation
Select encoding, fixed for both muxes:
- 0 regfile
- 1 EX/MEM ALU result
- 2 MEM/WB ALU result
- 3 MEM/WB load data
- 4 WB-late register
- 5 immediate
- 6 PC+8
- 7 zero

Tag state: each of the EX, MEM and WB slots holds {valid, dst, reg_write, is_load}.
- Normal cycle: EX←ID, MEM←EX, WB←MEM.
- A slot counts as a producer only if valid && reg_write && dst≠0.

Load-use hazard:
- `stall_id` = `id_valid` && !`flush` && EX slot is a load producer && ((`id_use_rs` && dst==`id_rs`) || (`id_use_rt` && dst==`id_rt`)).

Per-operand select, computed combinationally in ID and registered into `sel_a`/`sel_b`. Priority is first match wins:
1. `id_link_a` → 6 (A only); `id_imm_b` → 5 (B only).
2. Operand unused, or source reg 0 → 7.
3. EX producer matches → 1. A load never reaches this step because `stall_id` is asserted.
4. MEM producer matches → 3 if that producer is a load, else 2.
5. WB producer matches → 4. Compiled only with the macro; see Configuration.
6. Otherwise → 0.

Bubble (`stall_id` or `flush` or !`id_valid`):
- EX slot loads invalid; `sel_a`=`sel_b`=7; `ex_valid`=0.
- MEM←EX and WB←MEM still advance.
- If `flush` and a stall condition occur together, flush wins and `stall_id`=0.

## Timing
- Reset (`rst`=1 at a clock edge): all slots invalid; `sel_a`=`sel_b`=7; `ex_valid`=0.
- `stall_id` is 0 while reset state persists.
- Reset asserted mid-operation discards all tags on that edge; no forwarding from pre-reset instructions.
- Latency: the select is valid in EX exactly one cycle after the instruction is presented in ID.
- Load-use costs exactly one bubble. On the next cycle the load is in MEM and the consumer gets sel 3.
- No internal wrap or overflow; state is three tag slots only.

## Configuration
`GAC_FWD_WB_LATE_EN`:
- Defined: WB slot is tracked and priority step 5 is active. Covers a regfile that is written at the end of the cycle (no write-through) and a datapath with a WB-late holding register feeding mux input 4.
- Undefined: WB slot and step 5 are removed. The regfile is write-through, sel 4 is never produced, and a WB-only match yields 0.

## Test plan
- Reset: hold `rst` 2 cycles → `sel_a`=`sel_b`=7, `ex_valid`=0, `stall_id`=0; release with no `id_valid` → outputs unchanged.
- Back-to-back ALU: `add $3` then `sub` reading rs=$3 → sub in EX with `sel_a`=1; insert one unrelated instruction instead → `sel_a`=2.
- Load-use: `lw $5` then `add` rs=$5 → `stall_id`=1 for 1 cycle, bubble with sel 7/7, then `add` in EX with `sel_a`=3.
- Priority and $0: `add $4`, `or $4`, then consumer rs=$4 → `sel_a`=1 (nearest producer). Producer writing $0, consumer rs=$0 → `sel_a`=7.
- WB-late: producer $6 followed by two unrelated instructions, then consumer rt=$6 → `sel_b`=4 with `GAC_FWD_WB_LATE_EN` defined, 0 without. Same consumer with `id_imm_b`=1 → `sel_b`=5.
- Flush during hazard: `lw $2` in EX, ID reads $2, `flush`=1 → `stall_id`=0, EX bubble (7/7, `ex_valid`=0).
